// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a registered, channel-tagged output stage.
// Round-robin or fixed-priority pick; valid/ready on both sides.
module arb_mux #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0]    out_ch,
  input  logic                         out_ready
);

  localparam int CW = $clog2(NUM_CH);

  logic [CW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         base, idx, gidx;
  logic                  found;
  logic [NUM_CH-1:0]     grant;
  logic                  load_en, xfer;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         ch_q, ch_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Fixed priority is just a search that always starts at channel 0.
  assign base = (ARB_MODE == 1) ? '0 : ptr_q;

  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = base + CW'(k);
      if (!found && in_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  assign load_en  = !valid_q || out_ready;
  assign in_ready = (load_en && !reset) ? grant : '0;
  assign xfer     = |in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = ch_data[gidx];
      ch_d    = gidx;
      if (ARB_MODE == 0) begin
        ptr_d = gidx + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: round-robin and fixed-priority instances,
// directed vectors with hand-computed expected beats.
module tb_arb_mux;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rr_reset, fp_reset;
  logic [3:0]   rr_in_valid, fp_in_valid;
  logic [127:0] rr_in_data, fp_in_data;
  logic [3:0]   rr_in_ready, fp_in_ready;
  logic         rr_out_valid, fp_out_valid;
  logic [31:0]  rr_out_data, fp_out_data;
  logic [1:0]   rr_out_ch, fp_out_ch;
  logic         rr_out_ready, fp_out_ready;

  arb_mux #(.NUM_CH(4), .DATA_WIDTH(32), .ARB_MODE(0)) u_rr (
    .clk(clk), .reset(rr_reset),
    .in_valid(rr_in_valid), .in_data(rr_in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid),
    .out_data(rr_out_data), .out_ch(rr_out_ch),
    .out_ready(rr_out_ready)
  );

  arb_mux #(.NUM_CH(4), .DATA_WIDTH(32), .ARB_MODE(1)) u_fp (
    .clk(clk), .reset(fp_reset),
    .in_valid(fp_in_valid), .in_data(fp_in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid),
    .out_data(fp_out_data), .out_ch(fp_out_ch),
    .out_ready(fp_out_ready)
  );

  int checks = 0;
  int errors = 0;
  logic [33:0] rr_q[$];
  logic [33:0] fp_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rr(input logic [1:0] ch);
    rr_q.push_back({ch, 32'hA0 + 32'(ch)});
  endtask

  task automatic push_fp(input logic [1:0] ch);
    fp_q.push_back({ch, 32'hB0 + 32'(ch)});
  endtask

  // Monitors: pop one expected beat per observed output handshake.
  always @(negedge clk) begin
    if (rr_out_valid && rr_out_ready) begin
      if (rr_q.size() == 0) begin
        chk("rr_unexpected_beat", {30'd0, rr_out_ch, rr_out_data}, 64'hDEAD);
      end else begin
        chk("rr_beat", {30'd0, rr_out_ch, rr_out_data},
            {30'd0, rr_q.pop_front()});
      end
    end
    if (fp_out_valid && fp_out_ready) begin
      if (fp_q.size() == 0) begin
        chk("fp_unexpected_beat", {30'd0, fp_out_ch, fp_out_data}, 64'hDEAD);
      end else begin
        chk("fp_beat", {30'd0, fp_out_ch, fp_out_data},
            {30'd0, fp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_reset = 1'b1;
    fp_reset = 1'b1;
    rr_in_valid = 4'b1111;
    fp_in_valid = 4'b1111;
    rr_out_ready = 1'b1;
    fp_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rr_in_data[i*32 +: 32] = 32'hA0 + 32'(i);
      fp_in_data[i*32 +: 32] = 32'hB0 + 32'(i);
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(rr_in_ready), 64'h0);
    chk("rst_out_valid", 64'(rr_out_valid), 64'h0);
    chk("rst_out_data", 64'(rr_out_data), 64'h0);
    chk("rst_out_ch", 64'(rr_out_ch), 64'h0);
    chk("fp_rst_in_ready", 64'(fp_in_ready), 64'h0);

    // Round-robin fairness
    @(posedge clk);
    #1;
    rr_reset = 1'b0;
    push_rr(0); push_rr(1); push_rr(2); push_rr(3);
    push_rr(0); push_rr(1); push_rr(2);
    repeat (7) tick();

    // Back-pressure with A2 held
    rr_out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(rr_in_ready), 64'h0);
      chk("bp_out_valid", 64'(rr_out_valid), 64'h1);
      chk("bp_out_data", 64'(rr_out_data), 64'hA2);
      chk("bp_out_ch", 64'(rr_out_ch), 64'h2);
      tick();
    end
    rr_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(rr_in_ready), 64'h8);
    push_rr(3);
    tick();

    // Wrap and skip
    push_rr(0); push_rr(1); push_rr(2);
    repeat (3) tick();
    rr_in_valid = 4'b0011;
    @(negedge clk);
    chk("wrap_ready", 64'(rr_in_ready), 64'h1);
    push_rr(0); push_rr(1);
    tick();
    tick();
    rr_in_valid = 4'b1111;
    @(negedge clk);
    chk("ptr2_ready", 64'(rr_in_ready), 64'h4);
    push_rr(2);
    tick();
    rr_in_valid = 4'b0000;
    tick();
    @(negedge clk);
    chk("drain_out_valid", 64'(rr_out_valid), 64'h0);
    chk("drain_hold_data", 64'(rr_out_data), 64'hA2);
    chk("drain_hold_ch", 64'(rr_out_ch), 64'h2);

    // Mid-operation reset discards the held beat
    tick();
    rr_out_ready = 1'b0;
    rr_in_valid = 4'b1111;
    tick();
    chk("pre_rst_out_valid", 64'(rr_out_valid), 64'h1);
    chk("pre_rst_out_ch", 64'(rr_out_ch), 64'h3);
    #2;
    rr_reset = 1'b1;
    #1;
    chk("async_out_valid", 64'(rr_out_valid), 64'h0);
    chk("async_out_data", 64'(rr_out_data), 64'h0);
    chk("async_in_ready", 64'(rr_in_ready), 64'h0);
    tick();
    rr_reset = 1'b0;
    rr_out_ready = 1'b1;
    rr_in_valid = 4'b1010;
    @(negedge clk);
    chk("post_rst_ready", 64'(rr_in_ready), 64'h2);
    push_rr(1);
    tick();
    rr_in_valid = 4'b0000;
    tick();

    // Fixed priority: ch1 beats ch3 until it drops
    fp_reset = 1'b0;
    fp_in_valid = 4'b1010;
    @(negedge clk);
    chk("fp_ready_ch1", 64'(fp_in_ready), 64'h2);
    push_fp(1); push_fp(1); push_fp(1); push_fp(1);
    repeat (3) tick();
    @(negedge clk);
    chk("fp_ch3_starves", 64'(fp_in_ready), 64'h2);
    tick();
    fp_in_valid = 4'b1000;
    push_fp(3);
    tick();
    fp_in_valid = 4'b0000;
    repeat (3) tick();

    @(negedge clk);
    chk("rr_queue_empty", 64'(rr_q.size()), 64'h0);
    chk("fp_queue_empty", 64'(fp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
